// File: rtl/spcore_seq.sv
// Streaming-processor lane core: accepts one whole instruction per handshake and sequences READ/EXEC/MEM/WB itself.
// Latency accept->done: 3 for ALU ops, 2+MUL_CYCLES for MUL/MAD, 3+k for LOAD/STORE (ack k cycles after req), 2 for squashed/illegal.
// Backpressure: issue_ready is high only in IDLE; the memory request is held until mem_ack.
module spcore_seq #(
    parameter int DATA_W     = 16,
    parameter int NREGS      = 16,
    parameter int REG_AW     = 4,
    parameter int CORE_ID    = 0,
    parameter int N_CORES    = 1,
    parameter int MUL_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [3:0]        op,
    input  logic [REG_AW-1:0] x,
    input  logic [REG_AW-1:0] y,
    input  logic [REG_AW-1:0] z,
    input  logic [DATA_W-1:0] imm,
    input  logic              pred_en,
    output logic              done,
    output logic              err,
    output logic              P,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] addr,
    output logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] data_in,
    input  logic              mem_ack
);

    localparam logic [3:0] OP_CLEAR = 4'd0,  OP_LOADI = 4'd1,  OP_ADD   = 4'd2,  OP_SUB  = 4'd3;
    localparam logic [3:0] OP_MUL   = 4'd4,  OP_MAD   = 4'd5,  OP_INC   = 4'd6,  OP_CID  = 4'd7;
    localparam logic [3:0] OP_CN    = 4'd8,  OP_LOAD  = 4'd9,  OP_STORE = 4'd10, OP_SETP = 4'd11;
    localparam logic [3:0] OP_NOP   = 4'd12;

    // Counter only has to hold MUL_CYCLES-1.
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_MEM, S_WB} state_t;

    state_t              state_q;
    logic [3:0]          op_q;
    logic [REG_AW-1:0]   x_q, y_q, z_q;
    logic [DATA_W-1:0]   imm_q;
    logic                pred_q;
    logic [DATA_W-1:0]   rx_q, ry_q, rz_q, res_q;
    logic [DATA_W-1:0]   regs_q [NREGS];
    logic [CNT_W-1:0]    cnt_q;
    logic                wen_q, setp_q, ill_q;
    logic                p_q, done_q, err_q, mem_req_q, mem_we_q;
    logic [DATA_W-1:0]   addr_q, dout_q;

    logic [DATA_W-1:0]   prod_d, alu_d;
    logic                illegal_d, squash_d, is_mul_d;

    assign issue_ready = (state_q == S_IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign P           = p_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign addr        = addr_q;
    assign data_out    = dout_q;

    // Decode of the latched instruction and the execute result from latched operands.
    always_comb begin
        illegal_d = (op_q > OP_NOP);
        squash_d  = pred_q && !p_q;
        is_mul_d  = (op_q == OP_MUL) || (op_q == OP_MAD);
        prod_d    = ry_q * rz_q;          // low DATA_W bits of the product
        alu_d     = '0;
        case (op_q)
            OP_CLEAR: alu_d = '0;
            OP_LOADI: alu_d = imm_q;
            OP_ADD:   alu_d = ry_q + rz_q;
            OP_SUB:   alu_d = ry_q - rz_q;
            OP_MUL:   alu_d = prod_d;
            OP_MAD:   alu_d = rx_q + prod_d;
            OP_INC:   alu_d = rx_q + 1'b1;
            OP_CID:   alu_d = DATA_W'(CORE_ID);
            OP_CN:    alu_d = DATA_W'(N_CORES);
            OP_SETP:  alu_d = DATA_W'(ry_q < rz_q);   // bit 0 carries the new predicate
            default:  alu_d = '0;
        endcase
    end

    // Micro-sequencer: all state, register file and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            imm_q     <= '0;
            pred_q    <= 1'b0;
            rx_q      <= '0;
            ry_q      <= '0;
            rz_q      <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            wen_q     <= 1'b0;
            setp_q    <= 1'b0;
            ill_q     <= 1'b0;
            p_q       <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            addr_q    <= '0;
            dout_q    <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (issue_valid) begin
                        op_q    <= op;
                        x_q     <= x;
                        y_q     <= y;
                        z_q     <= z;
                        imm_q   <= imm;
                        pred_q  <= pred_en;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    // Operands are the pre-write values even when x, y and z alias.
                    rx_q  <= regs_q[x_q];
                    ry_q  <= regs_q[y_q];
                    rz_q  <= regs_q[z_q];
                    ill_q <= illegal_d;
                    if (illegal_d || squash_d) begin
                        wen_q   <= 1'b0;
                        setp_q  <= 1'b0;
                        state_q <= S_WB;
                    end else if (op_q == OP_LOAD || op_q == OP_STORE) begin
                        mem_req_q <= 1'b1;
                        mem_we_q  <= (op_q == OP_STORE);
                        addr_q    <= regs_q[y_q];
                        dout_q    <= regs_q[x_q];
                        wen_q     <= (op_q == OP_LOAD);
                        setp_q    <= 1'b0;
                        state_q   <= S_MEM;
                    end else begin
                        cnt_q   <= is_mul_d ? CNT_W'(MUL_CYCLES - 1) : '0;
                        wen_q   <= !(op_q == OP_SETP || op_q == OP_NOP);
                        setp_q  <= (op_q == OP_SETP);
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (cnt_q == '0) begin
                        res_q   <= alu_d;
                        state_q <= S_WB;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (!mem_we_q) res_q <= data_in;
                        state_q <= S_WB;
                    end
                end
                S_WB: begin
                    if (wen_q)  regs_q[x_q] <= res_q;
                    if (setp_q) p_q <= res_q[0];
                    done_q  <= 1'b1;
                    err_q   <= ill_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spcore_seq.sv
// Bench for spcore_seq: directed scenarios plus randomized instruction stream against an architectural model.
// Instructions are issued back to back; done latency and memory behaviour are observed at negedges.
// The memory responder inserts a chosen ack delay per instruction.
module tb_spcore_seq;

    localparam int MULC = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [3:0]  t_op = '0;
    logic [3:0]  t_x = '0, t_y = '0, t_z = '0;
    logic [15:0] t_imm = '0;
    logic        t_pred = 1'b0;
    logic        done, err, P, mem_req, mem_we;
    logic [15:0] addr, data_out;
    logic [15:0] data_in = '0;
    logic        mem_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    // architectural model
    logic [15:0] m_r [16];
    logic        m_p;
    logic [15:0] m_mem [logic [15:0]];

    // observations from the last instruction
    int          o_lat, o_wait, o_req, o_unstable;
    logic        o_err, o_p, o_we;
    logic [15:0] o_addr, o_dout;

    spcore_seq #(.DATA_W(16), .NREGS(16), .REG_AW(4), .CORE_ID(100), .N_CORES(200),
                 .MUL_CYCLES(MULC)) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .op(t_op), .x(t_x), .y(t_y), .z(t_z), .imm(t_imm), .pred_en(t_pred),
        .done(done), .err(err), .P(P), .mem_req(mem_req), .mem_we(mem_we),
        .addr(addr), .data_out(data_out), .data_in(data_in), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    function automatic int exp_lat(input logic [3:0] op, input logic pred, input int k);
        if (op > 12 || (pred && !m_p)) return 2;
        if (op == 4 || op == 5) return 2 + MULC;
        if (op == 9 || op == 10) return 3 + k;
        return 3;
    endfunction

    task automatic model_reset;
        for (int i = 0; i < 16; i++) m_r[i] = '0;
        m_p = 1'b1;
    endtask

    task automatic model_apply(input logic [3:0] op, input logic [3:0] xr, yr, zr,
                               input logic [15:0] imm, input logic pred);
        logic [31:0] prod;
        if (op > 12 || (pred && !m_p)) return;
        prod = {16'd0, m_r[yr]} * {16'd0, m_r[zr]};
        case (op)
            0:  m_r[xr] = 16'd0;
            1:  m_r[xr] = imm;
            2:  m_r[xr] = m_r[yr] + m_r[zr];
            3:  m_r[xr] = m_r[yr] - m_r[zr];
            4:  m_r[xr] = prod[15:0];
            5:  m_r[xr] = m_r[xr] + prod[15:0];
            6:  m_r[xr] = m_r[xr] + 16'd1;
            7:  m_r[xr] = 16'd100;
            8:  m_r[xr] = 16'd200;
            9:  m_r[xr] = m_mem[m_r[yr]];
            10: m_mem[m_r[yr]] = m_r[xr];
            11: m_p = (m_r[yr] < m_r[zr]);
            default: ;
        endcase
    endtask

    // Drives one instruction (caller is just after a negedge) and acts as memory with ack delay k.
    task automatic run(input logic [3:0] op, input logic [3:0] xr, yr, zr, input logic [15:0] imm,
                       input logic pred, input int k, input logic [15:0] ld);
        int n;
        bit got;
        t_op = op; t_x = xr; t_y = yr; t_z = zr; t_imm = imm; t_pred = pred;
        issue_valid = 1'b1;
        o_wait = 0;
        while (!issue_ready && o_wait < 20) begin
            @(negedge clk);
            o_wait++;
        end
        @(negedge clk);
        issue_valid = 1'b0;
        n = 1; got = 0; o_req = 0; o_unstable = 0;
        o_addr = '0; o_dout = '0; o_we = 1'b0;
        while (n < 60) begin
            if (done) begin
                got = 1;
                break;
            end
            if (mem_req) begin
                o_req++;
                if (o_req == 1) begin
                    o_addr = addr; o_dout = data_out; o_we = mem_we;
                end else if (addr !== o_addr || data_out !== o_dout || mem_we !== o_we) begin
                    o_unstable++;
                end
                mem_ack = (o_req == k + 1);
                data_in = (o_req == k + 1) ? ld : 16'hDEAD;
            end else begin
                mem_ack = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        mem_ack = 1'b0;
        o_lat = n - 1;
        o_err = err;
        o_p   = P;
        if (!got) begin
            checks++; errors++;
            $display("FAIL timeout op=%0d: no done within %0d cycles", op, n);
        end
    endtask

    task automatic exec(input logic [3:0] op, input logic [3:0] xr, yr, zr, input logic [15:0] imm,
                        input logic pred, input int k, input logic [15:0] ld);
        run(op, xr, yr, zr, imm, pred, k, ld);
        model_apply(op, xr, yr, zr, imm, pred);
    endtask

    // Observes R[r] through the store-data bus.
    task automatic read_reg(input logic [3:0] r, output logic [15:0] v);
        exec(4'd10, r, r, 4'd0, 16'd0, 1'b0, 0, 16'd0);
        v = o_dout;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({issue_ready, done, err, P, mem_req, mem_we} !== 6'b100100 || addr !== 0 || data_out !== 0) begin
            errors++;
            $display("FAIL reset_outputs got rdy/done/err/P/req/we=%b addr=%h dout=%h want 100100/0/0",
                     {issue_ready, done, err, P, mem_req, mem_we}, addr, data_out);
        end
        reset = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_alu;
        logic [15:0] v;
        exec(1, 0, 0, 0, 16'd11, 0, 0, 0);
        checks++; if (o_lat !== 3) begin errors++; $display("FAIL loadi_lat got %0d want 3", o_lat); end
        exec(1, 1, 0, 0, 16'd20, 0, 0, 0);
        exec(2, 2, 0, 1, 16'd0, 0, 0, 0);
        checks++; if (o_lat !== 3) begin errors++; $display("FAIL add_lat got %0d want 3", o_lat); end
        read_reg(2, v);
        checks++; if (v !== 16'd31) begin errors++; $display("FAIL add_val got %0d want 31", v); end
    endtask

    task automatic test_mul;
        logic [15:0] v;
        exec(5, 2, 0, 1, 16'd0, 0, 0, 0);
        checks++; if (o_lat !== 2 + MULC) begin errors++; $display("FAIL mad_lat got %0d want %0d", o_lat, 2 + MULC); end
        read_reg(2, v);
        checks++; if (v !== 16'd251) begin errors++; $display("FAIL mad_val got %0d want 251", v); end
        exec(4, 3, 0, 1, 16'd0, 0, 0, 0);
        checks++; if (o_lat !== 5) begin errors++; $display("FAIL mul_lat got %0d want 5", o_lat); end
        read_reg(3, v);
        checks++; if (v !== 16'd220) begin errors++; $display("FAIL mul_val got %0d want 220", v); end
    endtask

    task automatic test_wrap;
        logic [15:0] v;
        exec(1, 4, 0, 0, 16'hFFFF, 0, 0, 0);
        exec(6, 4, 0, 0, 16'd0, 0, 0, 0);
        read_reg(4, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL inc_wrap got %h want 0000", v); end
        exec(3, 5, 0, 1, 16'd0, 0, 0, 0);
        read_reg(5, v);
        checks++; if (v !== 16'hFFF7) begin errors++; $display("FAIL sub_wrap got %h want fff7", v); end
        exec(7, 7, 0, 0, 16'd0, 0, 0, 0);
        exec(8, 8, 0, 0, 16'd0, 0, 0, 0);
        read_reg(7, v);
        checks++; if (v !== 16'd100) begin errors++; $display("FAIL core_id got %0d want 100", v); end
        read_reg(8, v);
        checks++; if (v !== 16'd200) begin errors++; $display("FAIL n_cores got %0d want 200", v); end
    endtask

    task automatic test_pred;
        logic [15:0] v;
        exec(11, 0, 1, 0, 16'd0, 0, 0, 0);
        checks++; if (o_p !== 1'b0) begin errors++; $display("FAIL setp got P=%b want 0", o_p); end
        exec(2, 2, 0, 1, 16'd0, 1, 0, 0);
        checks++; if (o_lat !== 2) begin errors++; $display("FAIL squash_lat got %0d want 2", o_lat); end
        read_reg(2, v);
        checks++; if (v !== 16'd251) begin errors++; $display("FAIL squash_val got %0d want 251", v); end
        exec(14, 2, 0, 1, 16'd0, 0, 0, 0);
        checks++;
        if (o_err !== 1'b1 || o_lat !== 2) begin
            errors++; $display("FAIL illegal got err=%b lat=%0d want err=1 lat=2", o_err, o_lat);
        end
        read_reg(2, v);
        checks++; if (v !== 16'd251) begin errors++; $display("FAIL illegal_nowrite got %0d want 251", v); end
        exec(11, 0, 0, 1, 16'd0, 0, 0, 0);
        checks++; if (o_p !== 1'b1) begin errors++; $display("FAIL setp_true got P=%b want 1", o_p); end
    endtask

    task automatic test_mem;
        logic [15:0] v;
        exec(10, 1, 0, 0, 16'd0, 0, 3, 0);
        checks++;
        if (o_req !== 4 || o_unstable !== 0 || o_addr !== 16'd11 || o_dout !== 16'd20 || o_we !== 1'b1) begin
            errors++;
            $display("FAIL store got req=%0d unstable=%0d addr=%0d dout=%0d we=%b want 4/0/11/20/1",
                     o_req, o_unstable, o_addr, o_dout, o_we);
        end
        checks++; if (o_lat !== 6) begin errors++; $display("FAIL store_lat got %0d want 6", o_lat); end
        m_mem[16'd11] = 16'h1234;
        exec(9, 6, 0, 0, 16'd0, 0, 1, 16'h1234);
        checks++;
        if (o_we !== 1'b0 || o_addr !== 16'd11 || o_lat !== 4) begin
            errors++; $display("FAIL load got we=%b addr=%0d lat=%0d want 0/11/4", o_we, o_addr, o_lat);
        end
        read_reg(6, v);
        checks++; if (v !== 16'h1234) begin errors++; $display("FAIL load_val got %h want 1234", v); end
    endtask

    task automatic test_random;
        logic [3:0]  op, xr, yr, zr;
        logic [15:0] imm, ld, e_addr, e_dout, v;
        logic        pred, act_mem;
        int          k, e_lat;
        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(0, 15)); xr = 4'($urandom); yr = 4'($urandom); zr = 4'($urandom);
            imm = 16'($urandom); pred = ($urandom_range(0, 3) == 0); k = $urandom_range(0, 4);
            e_lat = exp_lat(op, pred, k);
            e_addr = m_r[yr]; e_dout = m_r[xr];
            act_mem = (op == 9 || op == 10) && !(pred && !m_p);
            if (op == 9 && !m_mem.exists(e_addr)) m_mem[e_addr] = 16'($urandom);
            ld = m_mem.exists(e_addr) ? m_mem[e_addr] : 16'h0;
            run(op, xr, yr, zr, imm, pred, k, ld);
            model_apply(op, xr, yr, zr, imm, pred);
            checks++;
            if (o_lat !== e_lat || o_wait !== 0 || o_err !== (op > 12) || o_p !== m_p) begin
                errors++;
                $display("FAIL rand_ctl i=%0d op=%0d got lat=%0d wait=%0d err=%b P=%b want %0d/0/%b/%b",
                         i, op, o_lat, o_wait, o_err, o_p, e_lat, (op > 12), m_p);
            end
            checks++;
            if (act_mem) begin
                if (o_req !== k + 1 || o_unstable !== 0 || o_addr !== e_addr || o_we !== (op == 10) ||
                    (op == 10 && o_dout !== e_dout)) begin
                    errors++;
                    $display("FAIL rand_mem i=%0d op=%0d got req=%0d unst=%0d addr=%h we=%b dout=%h want %0d/0/%h/%b/%h",
                             i, op, o_req, o_unstable, o_addr, o_we, o_dout, k + 1, e_addr, (op == 10), e_dout);
                end
            end else if (o_req !== 0) begin
                errors++;
                $display("FAIL rand_nomem i=%0d op=%0d got req=%0d want 0", i, op, o_req);
            end
        end
        for (int r = 0; r < 16; r++) begin
            e_dout = m_r[r];
            read_reg(4'(r), v);
            checks++;
            if (v !== e_dout) begin errors++; $display("FAIL rand_reg R%0d got %h want %h", r, v, e_dout); end
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] v;
        exec(1, 1, 0, 0, 16'd5, 0, 0, 0);
        exec(1, 0, 0, 0, 16'h0077, 0, 0, 0);
        exec(11, 0, 0, 1, 16'd0, 0, 0, 0);          // 0x77 < 5 is false -> P=0
        // MUL in flight, reset lands during EXEC
        t_op = 4; t_x = 3; t_y = 0; t_z = 1; t_pred = 0; issue_valid = 1'b1;
        @(negedge clk); issue_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0; #1;
        checks++;
        if (issue_ready !== 1'b1 || done !== 1'b0 || P !== 1'b1) begin
            errors++; $display("FAIL reset_exec got rdy=%b done=%b P=%b want 1/0/1", issue_ready, done, P);
        end
        @(negedge clk); reset = 1'b1; model_reset();
        exec(1, 0, 0, 0, 16'h0077, 0, 0, 0);
        // STORE in flight, reset lands while mem_req is high
        t_op = 10; t_x = 0; t_y = 0; issue_valid = 1'b1;
        @(negedge clk); issue_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || addr !== 16'h0077) begin
            errors++; $display("FAIL pre_reset_mem got req=%b addr=%h want 1/0077", mem_req, addr);
        end
        reset = 1'b0; #1;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || addr !== 16'h0 || data_out !== 16'h0 || P !== 1'b1) begin
            errors++;
            $display("FAIL reset_mem got req=%b we=%b addr=%h dout=%h P=%b want 0/0/0/0/1",
                     mem_req, mem_we, addr, data_out, P);
        end
        @(negedge clk); reset = 1'b1; model_reset();
        exec(1, 3, 0, 0, 16'h5A5A, 0, 0, 0);
        checks++; if (o_lat !== 3) begin errors++; $display("FAIL post_reset_lat got %0d want 3", o_lat); end
        read_reg(3, v);
        checks++; if (v !== 16'h5A5A) begin errors++; $display("FAIL post_reset_loadi got %h want 5a5a", v); end
        read_reg(0, v);
        checks++; if (v !== 16'h0) begin errors++; $display("FAIL post_reset_r0 got %h want 0000", v); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mul();
        test_wrap();
        test_pred();
        test_mem();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
